// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: access size codes and dump FSM state encoding for mem_data_arbiter
package mem_arb_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DONE} state_t;
endpackage

// File: rtl/mem_data_arbiter_if.sv
// mem_data_arbiter_if: cpu, debug-dump and mem_data signals around the arbiter
// slave modport is the arbiter side; master is the environment (cpu, debug unit, mem_data)
interface mem_data_arbiter_if #(parameter int NB_ADDR = 7, parameter int NB_DATA = 32);
  logic               i_cpu_write;
  logic               i_cpu_read;
  logic [1:0]         i_cpu_size;
  logic [NB_ADDR-1:0] i_cpu_addr;
  logic [NB_DATA-1:0] i_cpu_wdata;
  logic [NB_DATA-1:0] o_cpu_rdata;
  logic               o_cpu_misaligned;
  logic               i_dbg_dump_start;
  logic               i_dbg_ready;
  logic               o_dbg_valid;
  logic [NB_ADDR-1:0] o_dbg_addr;
  logic [NB_DATA-1:0] o_dbg_data;
  logic               o_dbg_busy;
  logic               o_dbg_done;
  logic               o_mem_write_flag;
  logic               o_mem_read_flag;
  logic               o_mem_word_enable;
  logic               o_mem_halfword_enable;
  logic               o_mem_byte_enable;
  logic [NB_ADDR-1:0] o_mem_addr;
  logic [NB_DATA-1:0] o_mem_write_data;
  logic [NB_DATA-1:0] i_mem_read_data;
  modport slave (
    input  i_cpu_write, i_cpu_read, i_cpu_size, i_cpu_addr, i_cpu_wdata,
    output o_cpu_rdata, o_cpu_misaligned,
    input  i_dbg_dump_start, i_dbg_ready,
    output o_dbg_valid, o_dbg_addr, o_dbg_data, o_dbg_busy, o_dbg_done,
    output o_mem_write_flag, o_mem_read_flag, o_mem_word_enable, o_mem_halfword_enable,
    output o_mem_byte_enable, o_mem_addr, o_mem_write_data,
    input  i_mem_read_data
  );
  modport master (
    output i_cpu_write, i_cpu_read, i_cpu_size, i_cpu_addr, i_cpu_wdata,
    input  o_cpu_rdata, o_cpu_misaligned,
    output i_dbg_dump_start, i_dbg_ready,
    input  o_dbg_valid, o_dbg_addr, o_dbg_data, o_dbg_busy, o_dbg_done,
    input  o_mem_write_flag, o_mem_read_flag, o_mem_word_enable, o_mem_halfword_enable,
    input  o_mem_byte_enable, o_mem_addr, o_mem_write_data,
    output i_mem_read_data
  );
endinterface

// File: rtl/dump_addr_gen.sv
// dump_addr_gen: dump word address counter with clear, step-by-4 and last-word flag
// ports: clk, rst (async), clear_i, step_i, addr_o (byte address), last_o (addr_o is final word)
module dump_addr_gen #(
  parameter int NB_ADDR      = 7,
  parameter int MEMORY_DEPTH = 128,
  parameter int WORD_COUNT   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               step_i,
  output logic [NB_ADDR-1:0] addr_o,
  output logic               last_o
);
  // an oversized WORD_COUNT is clamped to the memory so the counter can never wrap
  localparam int LAST = ((WORD_COUNT * 4 <= MEMORY_DEPTH) ? WORD_COUNT : MEMORY_DEPTH / 4) * 4 - 4;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  assign addr_d = clear_i ? '0 : step_i ? addr_q + NB_ADDR'(4) : addr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) addr_q <= '0;
    else addr_q <= addr_d;
  assign addr_o = addr_q;
  assign last_o = addr_q == NB_ADDR'(LAST);
endmodule

// File: rtl/mem_data_arbiter.sv
// mem_data_arbiter: shares the mem_data port between the MEM stage (absolute priority) and a debug word dump
// ports: i_clock, i_reset (async, active-high), bus (mem_data_arbiter_if.slave: cpu, dbg and mem_data groups)
// optional macro ALIGN_CHECK_EN: flags misaligned half/word accesses and suppresses misaligned stores
module mem_data_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NB_ADDR      = 7,
  parameter int NB_DATA      = 32,
  parameter int MEMORY_DEPTH = 128,
  parameter int WORD_COUNT   = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  mem_data_arbiter_if.slave     bus
);
  state_t             state_q, state_d;
  logic [NB_ADDR-1:0] dbg_addr_q;
  logic [NB_DATA-1:0] dbg_data_q;
  logic [NB_ADDR-1:0] cnt;
  logic               last, cpu_active, issue, hs, mis;
  assign cpu_active = bus.i_cpu_write | bus.i_cpu_read;
  assign hs         = (state_q == HOLD) & bus.i_dbg_ready;
  assign issue      = (state_q == ISSUE) & ~cpu_active;
`ifdef ALIGN_CHECK_EN
  assign mis = cpu_active & ((bus.i_cpu_size == SIZE_HALF & bus.i_cpu_addr[0]) |
                             (bus.i_cpu_size == SIZE_WORD & |bus.i_cpu_addr[1:0]));
`else
  assign mis = 1'b0;
`endif
  dump_addr_gen #(.NB_ADDR(NB_ADDR), .MEMORY_DEPTH(MEMORY_DEPTH), .WORD_COUNT(WORD_COUNT)) u_addr_gen (
    .clk    (i_clock),
    .rst    (i_reset),
    .clear_i((state_q == IDLE) & bus.i_dbg_dump_start),
    .step_i (hs & ~last),
    .addr_o (cnt),
    .last_o (last)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.i_dbg_dump_start ? ISSUE : IDLE;
      ISSUE:   state_d = cpu_active ? ISSUE : WAIT;
      WAIT:    state_d = HOLD;
      HOLD:    state_d = bus.i_dbg_ready ? (last ? DONE : ISSUE) : HOLD;
      default: state_d = IDLE;
    endcase
  end
  // the read issued in ISSUE returns during WAIT, so capture there regardless of later cpu traffic
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      state_q    <= IDLE;
      dbg_addr_q <= '0;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      dbg_addr_q <= (state_q == WAIT) ? cnt : dbg_addr_q;
      dbg_data_q <= (state_q == WAIT) ? bus.i_mem_read_data : dbg_data_q;
    end
  assign bus.o_cpu_rdata           = bus.i_mem_read_data;
  assign bus.o_cpu_misaligned      = mis;
  assign bus.o_dbg_valid           = state_q == HOLD;
  assign bus.o_dbg_addr            = dbg_addr_q;
  assign bus.o_dbg_data            = dbg_data_q;
  assign bus.o_dbg_busy            = (state_q == ISSUE) | (state_q == WAIT) | (state_q == HOLD);
  assign bus.o_dbg_done            = state_q == DONE;
  assign bus.o_mem_write_flag      = ~i_reset & bus.i_cpu_write & ~mis;
  assign bus.o_mem_read_flag       = ~i_reset & (cpu_active ? bus.i_cpu_read & ~bus.i_cpu_write : issue);
  assign bus.o_mem_word_enable     = ~i_reset & (cpu_active ? bus.i_cpu_size == SIZE_WORD : issue);
  assign bus.o_mem_halfword_enable = ~i_reset & cpu_active & (bus.i_cpu_size == SIZE_HALF);
  assign bus.o_mem_byte_enable     = ~i_reset & cpu_active & (bus.i_cpu_size == SIZE_BYTE);
  assign bus.o_mem_addr            = i_reset ? '0 : cpu_active ? bus.i_cpu_addr : issue ? cnt : '0;
  assign bus.o_mem_write_data      = (~i_reset & cpu_active) ? bus.i_cpu_wdata : '0;
endmodule

// File: tb/tb_mem_data_arbiter.sv
// tb_mem_data_arbiter: directed vector table plus dump sequences against a byte-array mem_data model
module tb_mem_data_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
`ifdef ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif
  mem_data_arbiter_if #(.NB_ADDR(7), .NB_DATA(32)) bus ();
  mem_data_arbiter #(.NB_ADDR(7), .NB_DATA(32), .MEMORY_DEPTH(128), .WORD_COUNT(4)) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );
  logic [7:0] mem [128];
  always @(posedge clk) begin
    if (bus.o_mem_write_flag) begin
      if (bus.o_mem_byte_enable) mem[bus.o_mem_addr] <= bus.o_mem_write_data[7:0];
      if (bus.o_mem_halfword_enable | bus.o_mem_word_enable) begin
        mem[bus.o_mem_addr]         <= bus.o_mem_write_data[7:0];
        mem[bus.o_mem_addr + 7'd1]  <= bus.o_mem_write_data[15:8];
      end
      if (bus.o_mem_word_enable) begin
        mem[bus.o_mem_addr + 7'd2]  <= bus.o_mem_write_data[23:16];
        mem[bus.o_mem_addr + 7'd3]  <= bus.o_mem_write_data[31:24];
      end
    end
    if (bus.o_mem_read_flag)
      bus.i_mem_read_data <= {mem[bus.o_mem_addr + 7'd3], mem[bus.o_mem_addr + 7'd2],
                              mem[bus.o_mem_addr + 7'd1], mem[bus.o_mem_addr]};
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_wf"}, bus.o_mem_write_flag, 0);
    chk({nm, "_rf"}, bus.o_mem_read_flag, 0);
    chk({nm, "_en"}, {bus.o_mem_word_enable, bus.o_mem_halfword_enable, bus.o_mem_byte_enable}, 0);
    chk({nm, "_maddr"}, bus.o_mem_addr, 0);
    chk({nm, "_wdata"}, bus.o_mem_write_data, 0);
    chk({nm, "_dbg"}, {bus.o_dbg_valid, bus.o_dbg_busy, bus.o_dbg_done}, 0);
    chk({nm, "_daddr"}, bus.o_dbg_addr, 0);
    chk({nm, "_ddata"}, bus.o_dbg_data, 0);
  endtask
  typedef struct {
    logic w, r; logic [1:0] size; logic [6:0] addr; logic [31:0] wdata;
    logic wf, rf, we, he, be, mis; logic [6:0] maddr; logic [31:0] mwdata; logic rd_chk; logic [31:0] rdata;
  } vec_t;
  vec_t vt [8];
  task automatic dump(input bit tog, input int stall_beat, input int stall_len, input int abort_beat);
    int  beats = 0, stalled = 0, cyc = 0, stray = 0;
    bit  fin = 0, aborted = 0;
    @(negedge clk);
    bus.i_dbg_dump_start = 1'b1;
    bus.i_dbg_ready = 1'b0;
    @(negedge clk);
    bus.i_dbg_dump_start = 1'b0;
    chk("busy_after_start", bus.o_dbg_busy, 1);
    while (!fin && cyc < 200) begin
      bus.i_cpu_read = tog && (cyc % 2 == 1);
      bus.i_cpu_size = 2'b10;
      bus.i_cpu_addr = 7'h40;
      bus.i_dbg_ready = !(beats == stall_beat && stalled < stall_len);
      #1;
      if (bus.i_cpu_read) chk("cpu_priority_addr", bus.o_mem_addr, 7'h40);
      if (bus.o_dbg_valid && bus.o_mem_read_flag && !bus.i_cpu_read) stray++;
      if (bus.o_dbg_done) begin
        chk("done_beats", beats, 4);
        chk("done_busy", bus.o_dbg_busy, 0);
        fin = 1;
      end else if (bus.o_dbg_valid) begin
        if (beats == abort_beat) begin
          rst = 1'b1;
          #1;
          chk_zero("abort_reset");
          fin = 1;
          aborted = 1;
        end else begin
          chk("beat_addr", bus.o_dbg_addr, 7'(beats * 4));
          chk("beat_data", bus.o_dbg_data, 32'(beats) * 32'h11111111);
          if (bus.i_dbg_ready) beats++;
          else stalled++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.i_cpu_read = 1'b0;
    bus.i_dbg_ready = 1'b0;
    chk("dump_timeout", fin, 1);
    chk("hold_reads", stray, 0);
    if (stall_beat >= 0) chk("stall_cycles", stalled, stall_len);
    if (!aborted) begin
      #1;
      chk("done_pulse_len", bus.o_dbg_done, 0);
    end
  endtask
  initial begin
    bus.i_cpu_write = 0; bus.i_cpu_read = 0; bus.i_cpu_size = 0; bus.i_cpu_addr = 0; bus.i_cpu_wdata = 0;
    bus.i_dbg_dump_start = 0; bus.i_dbg_ready = 0;
    vt[0] = '{1,0,2'b10,7'd8,32'hDEADBEEF, 1,0,1,0,0,0, 7'd8,32'hDEADBEEF, 0,0};
    vt[1] = '{0,1,2'b10,7'd8,32'h0,        0,1,1,0,0,0, 7'd8,32'h0,        1,32'hDEADBEEF};
    vt[2] = '{1,1,2'b00,7'd5,32'hA5,       1,0,0,0,1,0, 7'd5,32'hA5,       0,0};
    vt[3] = '{0,1,2'b01,7'd6,32'h1234,     0,1,0,1,0,0, 7'd6,32'h1234,     0,0};
    vt[4] = '{1,0,2'b01,7'd3,32'hBEEF,     !ALN,0,0,1,0,ALN, 7'd3,32'hBEEF, 0,0};
    vt[5] = '{0,1,2'b10,7'd2,32'h0,        0,1,1,0,0,ALN, 7'd2,32'h0,      0,0};
    vt[6] = '{0,0,2'b10,7'd9,32'hFFFF,     0,0,0,0,0,0, 7'd0,32'h0,        0,0};
    vt[7] = '{1,0,2'b11,7'd4,32'h77,       1,0,0,0,0,0, 7'd4,32'h77,       0,0};
    repeat (2) @(negedge clk);
    chk_zero("reset_state");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.i_cpu_write = vt[i].w; bus.i_cpu_read = vt[i].r; bus.i_cpu_size = vt[i].size;
      bus.i_cpu_addr = vt[i].addr; bus.i_cpu_wdata = vt[i].wdata;
      #1;
      chk($sformatf("v%0d_wf", i), bus.o_mem_write_flag, vt[i].wf);
      chk($sformatf("v%0d_rf", i), bus.o_mem_read_flag, vt[i].rf);
      chk($sformatf("v%0d_en", i), {bus.o_mem_word_enable, bus.o_mem_halfword_enable, bus.o_mem_byte_enable},
          {vt[i].we, vt[i].he, vt[i].be});
      chk($sformatf("v%0d_mis", i), bus.o_cpu_misaligned, vt[i].mis);
      chk($sformatf("v%0d_maddr", i), bus.o_mem_addr, vt[i].maddr);
      chk($sformatf("v%0d_mwdata", i), bus.o_mem_write_data, vt[i].mwdata);
      if (vt[i].rd_chk) begin
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_rdata", i), bus.o_cpu_rdata, vt[i].rdata);
      end
    end
    @(negedge clk);
    bus.i_cpu_write = 1; bus.i_cpu_read = 0; bus.i_cpu_size = 2'b10; bus.i_cpu_addr = 7'd8; bus.i_cpu_wdata = 32'hCAFEF00D;
    rst = 1'b1;
    #1;
    chk_zero("midsim_reset");
    @(negedge clk);
    bus.i_cpu_write = 0;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.i_cpu_write = 1; bus.i_cpu_size = 2'b10; bus.i_cpu_addr = 7'(4 * k); bus.i_cpu_wdata = 32'(k) * 32'h11111111;
    end
    @(negedge clk);
    bus.i_cpu_write = 0;
    dump(0, -1, 0, -1);
    dump(1, -1, 0, -1);
    dump(0, 2, 5, -1);
    dump(0, -1, 0, 2);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("no_done_after_abort", {bus.o_dbg_done, bus.o_dbg_valid, bus.o_dbg_busy}, 0);
      @(negedge clk);
    end
    dump(0, -1, 0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
